// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter subsystem.
package counter_pkg;

    localparam int unsigned DCNT_WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dcnt_state_t;

endpackage : counter_pkg

// File: rtl/count_reg.sv
// WIDTH-bit register with async active-low clear and synchronous load.
module count_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : count_reg

// File: rtl/down_counter_4b.sv
// Loadable down counter with one-cycle terminal-count pulse and optional
// auto-reload of the last loaded value; used as an interval/timeout timer.
module down_counter_4b
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DCNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    dcnt_state_t      state_q;
    dcnt_state_t      state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             count_ld;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             tc_d;
    logic             busy_q;
    logic             busy_d;
    logic             terminal;

    // A terminal event is the enabled decrement out of a count of one.
    assign terminal = (state_q == RUN) && en && (count_q == WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val != '0) ? RUN : IDLE;
        end else if (terminal && !auto_reload) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        count_d  = count_q;
        count_ld = 1'b0;
        tc_d     = 1'b0;
        if (load) begin
            count_ld = 1'b1;
            count_d  = load_val;
        end else if (terminal) begin
            count_ld = 1'b1;
            count_d  = auto_reload ? reload_q : '0;
            tc_d     = 1'b1;
        end else if ((state_q == RUN) && en && (count_q != '0)) begin
            count_ld = 1'b1;
            count_d  = count_q - WIDTH'(1);
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tc_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            busy_q <= busy_d;
        end
    end

    count_reg #(.WIDTH(WIDTH)) u_count_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (count_ld),
        .d       (count_d),
        .q       (count_q)
    );

    count_reg #(.WIDTH(WIDTH)) u_reload_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .d       (load_val),
        .q       (reload_q)
    );

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule : down_counter_4b

// File: tb/tb_down_counter_4b.sv
// Bench for down_counter_4b: directed test-plan scenarios plus random traffic
// compared against a behavioural timer model.
module tb_down_counter_4b;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int n_tests;
    int n_fail;

    // Reference model state
    int m_cnt;
    int m_rel;
    bit m_run;
    bit m_tc;

    down_counter_4b #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_rel = 0;
        m_run = 0;
        m_tc  = 0;
    endtask

    task automatic model_step(input bit e, input bit ld, input int lv, input bit ar);
        m_tc = 0;
        if (ld) begin
            m_rel = lv;
            m_cnt = lv;
            m_run = (lv != 0);
        end else if (m_run && e) begin
            if (m_cnt == 1) begin
                m_tc = 1;
                if (ar) begin
                    m_cnt = m_rel;
                end else begin
                    m_cnt = 0;
                    m_run = 0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, int'(count), m_cnt);
        check({tag, ".tc"},    int'(tc),    int'(m_tc));
        check({tag, ".busy"},  int'(busy),  int'(m_run));
    endtask

    // Apply one cycle of inputs, advance model and DUT, sample 1 time unit later.
    task automatic step(input bit e, input bit ld, input int lv, input bit ar, input string tag);
        en          = e;
        load        = ld;
        load_val    = W'(lv);
        auto_reload = ar;
        @(posedge clk);
        model_step(e, ld, lv, ar);
        #1;
        check_model(tag);
    endtask

    initial begin
        int tc_cycles;
        int steps;
        bit seen;
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        en          = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        auto_reload = 1'b0;
        model_reset();
        #12;
        check("reset.count", int'(count), 0);
        check("reset.tc",    int'(tc),    0);
        check("reset.busy",  int'(busy),  0);
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot: 5,4,3,2,1,0 with tc only at 0
        step(1, 1, 5, 0, "oneshot_load");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "oneshot");
        check("oneshot.final_count", int'(count), 0);
        check("oneshot.final_tc",    int'(tc),    1);
        check("oneshot.final_busy",  int'(busy),  0);
        step(1, 0, 0, 0, "oneshot_hold");

        // Auto-reload: period 3
        step(1, 1, 3, 1, "autoreload_load");
        for (int i = 0; i < 9; i++) step(1, 0, 0, 1, "autoreload");

        // Enable gating
        step(1, 1, 4, 0, "gate_load");
        step(1, 0, 0, 0, "gate");
        step(0, 0, 0, 0, "gate");
        step(1, 0, 0, 0, "gate");
        step(0, 0, 0, 0, "gate");
        step(1, 0, 0, 0, "gate");
        step(1, 0, 0, 0, "gate");
        check("gate.final_tc", int'(tc), 1);

        // Load priority over a terminal event
        step(1, 1, 2, 0, "prio_load");
        step(1, 0, 0, 0, "prio_to_one");
        step(1, 1, 9, 0, "prio_collide");
        check("prio.count", int'(count), 9);
        check("prio.tc",    int'(tc),    0);
        check("prio.busy",  int'(busy),  1);

        // Load zero: stays idle, no tc
        step(1, 1, 0, 1, "zero_load");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, "zero_idle");
        check("zero.busy", int'(busy), 0);

        // Load 15: terminal after exactly 15 enabled cycles, no wrap
        step(1, 1, 15, 0, "max_load");
        tc_cycles = 0;
        seen      = 0;
        steps     = 0;
        while (!seen && steps < 20) begin
            step(1, 0, 0, 0, "max");
            steps++;
            if (tc) begin
                seen      = 1;
                tc_cycles = steps;
            end
        end
        check("max.cycles_to_tc", tc_cycles, 15);
        step(1, 0, 0, 0, "max_nowrap");
        check("max.nowrap", int'(count), 0);

        // Load 1 with auto-reload: tc every enabled cycle
        step(1, 1, 1, 1, "one_load");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, "one");
            check("one.tc_every", int'(tc), 1);
        end

        // Asynchronous reset mid-count at count 7
        step(1, 1, 9, 0, "rst_load");
        step(1, 0, 0, 0, "rst_run");
        step(1, 0, 0, 0, "rst_run");
        check("rst.pre_count", int'(count), 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async.count", int'(count), 0);
        check("rst_async.tc",    int'(tc),    0);
        check("rst_async.busy",  int'(busy),  0);
        model_reset();
        #3;
        reset_n = 1'b1;
        step(1, 0, 0, 0, "rst_after");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit ld;
            bit ar;
            int lv;
            e  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 9) == 0);
            ar = ($urandom_range(0, 2) != 0);
            lv = int'($urandom_range(0, 15));
            if (ld && $urandom_range(0, 5) == 0) lv = ($urandom_range(0, 1) != 0) ? 1 : 0;
            step(e, ld, lv, ar, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_down_counter_4b
